// File: rtl/output_flit_tx.sv
// Router output-port transmitter: round-robin arbitration over input datapaths,
// per-VC wormhole locking and a single registered valid/ready output stage.
package ravenoc_pkg;
   localparam int FlitWidth  = 34;
   localparam int NumVirtChn = 4;
   localparam int VcWidth    = 2;

   typedef struct packed {
      logic [FlitWidth-1:0] fdata;
      logic [VcWidth-1:0]   vc_id;
      logic                 valid;
   } s_flit_req_t;

   typedef struct packed {
      logic ready;
   } s_flit_resp_t;
endpackage

module output_flit_tx
   import ravenoc_pkg::*;
#(
   parameter int NumInputs   = 4,
   parameter int FlitTpWidth = 2
) (
   input  logic                            clk,
   input  logic                            arst,
   input  s_flit_req_t  [NumInputs-1:0]    fin_req_i,
   output s_flit_resp_t [NumInputs-1:0]    fin_resp_o,
   output s_flit_req_t                     fout_req_o,
   input  s_flit_resp_t                    fout_resp_i,
   output logic [NumVirtChn-1:0]           vc_lock_o,
   output logic                            busy_o,
   output logic                            err_o
);
   localparam int IdxW = (NumInputs > 1) ? $clog2(NumInputs) : 1;
   localparam logic [FlitTpWidth-1:0] TpHead   = FlitTpWidth'(0);
   localparam logic [FlitTpWidth-1:0] TpTail   = FlitTpWidth'(2);
   localparam logic [FlitTpWidth-1:0] TpSingle = FlitTpWidth'(3);

   logic [NumVirtChn-1:0]           lock_vld_q, lock_vld_d;
   logic [NumVirtChn-1:0][IdxW-1:0] lock_owner_q, lock_owner_d;
   logic [IdxW-1:0]                 rr_q, rr_d;
   s_flit_req_t                     out_q, out_d;
   logic                            err_q, err_d;

   logic [NumInputs-1:0] elig, proto_err;
   logic [IdxW-1:0]      grant;
   logic                 found, load;
   logic [IdxW:0]        idx_w;

   // Eligibility looks only at registered lock state, so a freed VC is reusable next cycle.
   for (genvar g = 0; g < NumInputs; g++) begin : g_elig
      logic [FlitTpWidth-1:0] tp;
      logic [VcWidth-1:0]     vc;
      logic                   owned, is_hd;
      assign tp           = fin_req_i[g].fdata[FlitWidth-1 -: FlitTpWidth];
      assign vc           = fin_req_i[g].vc_id;
      assign owned        = lock_vld_q[vc] && (lock_owner_q[vc] == IdxW'(g));
      assign is_hd        = (tp == TpHead) || (tp == TpSingle);
      assign elig[g]      = fin_req_i[g].valid && (is_hd ? !lock_vld_q[vc] : owned);
      assign proto_err[g] = fin_req_i[g].valid && !is_hd && !owned;
   end

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx_w = '0;
      for (int k = 0; k < NumInputs; k++) begin
         idx_w = {1'b0, rr_q} + (IdxW+1)'(k);
         if (idx_w >= (IdxW+1)'(NumInputs)) idx_w = idx_w - (IdxW+1)'(NumInputs);
         if (!found && elig[idx_w[IdxW-1:0]]) begin
            found = 1'b1;
            grant = idx_w[IdxW-1:0];
         end
      end
   end

   assign load = (!out_q.valid || fout_resp_i.ready) && found;

   always_comb begin
      for (int i = 0; i < NumInputs; i++)
         fin_resp_o[i].ready = load && !arst && (grant == IdxW'(i));
   end

   always_comb begin
      logic [FlitTpWidth-1:0] g_tp;
      logic [VcWidth-1:0]     g_vc;
      g_tp         = fin_req_i[grant].fdata[FlitWidth-1 -: FlitTpWidth];
      g_vc         = fin_req_i[grant].vc_id;
      out_d        = out_q;
      lock_vld_d   = lock_vld_q;
      lock_owner_d = lock_owner_q;
      rr_d         = rr_q;
      err_d        = err_q | (|proto_err);
      if (load) begin
         out_d.fdata = fin_req_i[grant].fdata;
         out_d.vc_id = g_vc;
         out_d.valid = 1'b1;
         rr_d        = (grant == IdxW'(NumInputs-1)) ? '0 : grant + 1'b1;
         if (g_tp == TpHead) begin
            lock_vld_d[g_vc]   = 1'b1;
            lock_owner_d[g_vc] = grant;
         end else if (g_tp == TpTail) begin
            lock_vld_d[g_vc]   = 1'b0;
         end
      end else if (fout_resp_i.ready) begin
         out_d.valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         out_q        <= '0;
         lock_vld_q   <= '0;
         lock_owner_q <= '0;
         rr_q         <= '0;
         err_q        <= 1'b0;
      end else begin
         out_q        <= out_d;
         lock_vld_q   <= lock_vld_d;
         lock_owner_q <= lock_owner_d;
         rr_q         <= rr_d;
         err_q        <= err_d;
      end
   end

   assign fout_req_o = out_q;
   assign vc_lock_o  = lock_vld_q;
   assign busy_o     = out_q.valid | (|lock_vld_q);
   assign err_o      = err_q;
endmodule
